// File: rtl/uart_rx_pkg.sv
// Shared types, constants and helpers for the 8N1 serial receiver.
package uart_rx_pkg;

   // Clock cycles per bit at 115200 baud from a 12 MHz system clock.
   localparam int B115200 = 104;

   // Number of line samples in one frame: start + 8 data + stop.
   localparam logic [3:0] FRAME_BITS = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RECV = 2'b01,
      ST_LOAD = 2'b10
   } rx_state_e;

   // A falling edge on the synchronized line marks a candidate start bit.
   function automatic logic start_edge(input logic prev_v, input logic cur_v);
      return prev_v & ~cur_v;
   endfunction

   // A frame is well formed when the start sample is low and the stop sample is high.
   function automatic logic frame_ok(input logic [9:0] frame_v);
      return frame_v[9] & ~frame_v[0];
   endfunction

endpackage

// File: rtl/uart_rx_baudgen.sv
// Receive-side baud generator: free counter while enabled, one-cycle pulse at mid-bit.
module baudgen_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUDRATE = B115200
) (
   input  logic rstn,
   input  logic clk,
   input  logic clk_ena,
   output logic clk_out
);

   localparam int W = $clog2(BAUDRATE);
   localparam logic [W-1:0] CNT_TOP  = W'(BAUDRATE - 1);
   localparam logic [W-1:0] CNT_HALF = W'(BAUDRATE >> 1);

   logic [W-1:0] cnt_r;

   // Count 0..BAUDRATE-1 while enabled; park at zero when disabled so each frame starts aligned.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {W{1'b0}};
      end else if (!clk_ena) begin
         cnt_r <= {W{1'b0}};
      end else if (cnt_r == CNT_TOP) begin
         cnt_r <= {W{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign clk_out = clk_ena & (cnt_r == CNT_HALF);

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizer, start detect, mid-bit sampling, framed byte output.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUDRATE = B115200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rcv,
   output logic       busy,
   output logic       frame_err
);

   logic       rx_meta_r;
   logic       rx_sync_r;
   logic       rx_d_r;
   logic       start_edge_s;
   logic       baud_ena_s;
   logic       baud_tick_s;
   logic [9:0] shifter_r;
   logic [3:0] bitc_r;
   rx_state_e  state_r;
   rx_state_e  state_next_s;
   logic [7:0] data_r;
   logic       rcv_r;
   logic       busy_r;
   logic       frame_err_r;

   // Two-flop synchronizer on the pin plus one history flop for edge detection; idle level is high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_d_r    <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_d_r    <= rx_sync_r;
      end
   end

   assign start_edge_s = start_edge(rx_d_r, rx_sync_r);

   baudgen_rx #(
      .BAUDRATE (BAUDRATE)
   ) u_baudgen (
      .rstn    (rstn),
      .clk     (clk),
      .clk_ena (baud_ena_s),
      .clk_out (baud_tick_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a high start sample means the edge was noise, so drop back to idle.
   always_comb begin
      state_next_s = state_r;
      baud_ena_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_edge_s) begin
               state_next_s = ST_RECV;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            baud_ena_s = 1'b1;
            if (baud_tick_s && (bitc_r == 4'd0) && rx_sync_r) begin
               state_next_s = ST_IDLE;
            end else if (bitc_r == FRAME_BITS) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_RECV;
            end
         end
         ST_LOAD: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Shift in one line sample per mid-bit tick, LSB first; bit count clears whenever idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shifter_r <= 10'h000;
         bitc_r    <= 4'd0;
      end else if (state_r == ST_IDLE) begin
         bitc_r <= 4'd0;
      end else if ((state_r == ST_RECV) && baud_tick_s) begin
         shifter_r <= {rx_sync_r, shifter_r[9:1]};
         bitc_r    <= bitc_r + 4'd1;
      end else begin
         shifter_r <= shifter_r;
         bitc_r    <= bitc_r;
      end
   end

   // Output registers: good frames update data with a one-cycle rcv; bad stop bit flags frame_err only.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_r      <= 8'h00;
         rcv_r       <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         busy_r <= (state_next_s != ST_IDLE);
         if ((state_r == ST_LOAD) && frame_ok(shifter_r)) begin
            data_r      <= shifter_r[8:1];
            rcv_r       <= 1'b1;
            frame_err_r <= 1'b0;
         end else if (state_r == ST_LOAD) begin
            rcv_r       <= 1'b0;
            frame_err_r <= 1'b1;
         end else begin
            rcv_r       <= 1'b0;
            frame_err_r <= 1'b0;
         end
      end
   end

   assign data      = data_r;
   assign rcv       = rcv_r;
   assign busy      = busy_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames at 104 cycles/bit plus a full byte sweep on a fast instance.
module tb_uart_rx;

   localparam int BAUD      = 104;
   localparam int BAUD_FAST = 16;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       rstn;
   logic       rx;
   logic [7:0] data;
   logic       rcv;
   logic       busy;
   logic       frame_err;

   logic       rx_f;
   logic [7:0] data_f;
   logic       rcv_f;
   logic       busy_f;
   logic       frame_err_f;

   int   checks;
   int   errors;
   exp_t q_main[$];
   exp_t q_fast[$];
   logic busy_seen;

   uart_rx #(.BAUDRATE(BAUD)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .rx        (rx),
      .data      (data),
      .rcv       (rcv),
      .busy      (busy),
      .frame_err (frame_err)
   );

   uart_rx #(.BAUDRATE(BAUD_FAST)) dut_fast (
      .clk       (clk),
      .rstn      (rstn),
      .rx        (rx_f),
      .data      (data_f),
      .rcv       (rcv_f),
      .busy      (busy_f),
      .frame_err (frame_err_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor for the 104-cycle instance: every strobe must match the head of the queue.
   always @(negedge clk) begin
      if (rstn && (rcv || frame_err)) begin
         checks++;
         if (rcv && frame_err) begin
            errors++;
            $display("FAIL main_excl: rcv and frame_err both high, data %0h", data);
         end else if (q_main.size() == 0) begin
            errors++;
            $display("FAIL main_unexpected: rcv=%0b frame_err=%0b data=%0h, expected no strobe", rcv, frame_err, data);
         end else begin
            exp_t e;
            e = q_main.pop_front();
            if ((frame_err !== e.err) || (data !== e.data)) begin
               errors++;
               $display("FAIL main_frame: got err=%0b data=%0h, expected err=%0b data=%0h", frame_err, data, e.err, e.data);
            end
         end
      end
      if (busy) busy_seen = 1'b1;
   end

   // Monitor for the fast instance.
   always @(negedge clk) begin
      if (rstn && (rcv_f || frame_err_f)) begin
         checks++;
         if (q_fast.size() == 0) begin
            errors++;
            $display("FAIL fast_unexpected: rcv=%0b frame_err=%0b data=%0h, expected no strobe", rcv_f, frame_err_f, data_f);
         end else begin
            exp_t e;
            e = q_fast.pop_front();
            if ((frame_err_f !== e.err) || (data_f !== e.data) || (rcv_f !== 1'b1)) begin
               errors++;
               $display("FAIL fast_frame: got err=%0b data=%0h, expected err=%0b data=%0h", frame_err_f, data_f, e.err, e.data);
            end
         end
      end
   end

   task automatic send_bit(input logic v);
      rx = v;
      repeat (BAUD) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_v);
   endtask

   task automatic send_bit_fast(input logic v);
      rx_f = v;
      repeat (BAUD_FAST) @(posedge clk);
      #1;
   endtask

   task automatic send_frame_fast(input logic [7:0] b);
      send_bit_fast(1'b0);
      for (int i = 0; i < 8; i++) send_bit_fast(b[i]);
      send_bit_fast(1'b1);
   endtask

   task automatic idle_bits(input int n);
      repeat (n * BAUD) @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      busy_seen = 1'b0;
      rx        = 1'b1;
      rx_f      = 1'b1;
      rstn      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_data", {24'h0, data}, 32'h00);
      check("reset_rcv", {31'h0, rcv}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_ferr", {31'h0, frame_err}, 32'h0);
      rstn = 1'b1;
      idle_bits(2);

      // Single byte 0x55.
      q_main.push_back('{err: 1'b0, data: 8'h55});
      send_frame(8'h55, 1'b1);
      idle_bits(1);
      check("t1_busy_low", {31'h0, busy}, 32'h0);
      check("t1_data_held", {24'h0, data}, 32'h55);

      // Back-to-back frames with no idle gap.
      q_main.push_back('{err: 1'b0, data: 8'hA3});
      send_frame(8'hA3, 1'b1);
      q_main.push_back('{err: 1'b0, data: 8'h0F});
      send_frame(8'h0F, 1'b1);
      idle_bits(1);
      check("t2_data", {24'h0, data}, 32'h0F);

      // Stop bit low: frame_err with data held, then line stuck low must stay silent.
      q_main.push_back('{err: 1'b1, data: 8'h0F});
      send_frame(8'hFF, 1'b0);
      idle_bits(20);
      check("t3_busy_stuck_low", {31'h0, busy}, 32'h0);
      check("t3_queue_drained", q_main.size(), 32'd0);
      rx = 1'b1;
      idle_bits(2);
      check("t3_data_kept", {24'h0, data}, 32'h0F);

      // Glitch of a quarter bit: busy pulses, no strobe.
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (BAUD / 4) @(posedge clk);
      #1;
      rx = 1'b1;
      idle_bits(3);
      check("t4_busy_seen", {31'h0, busy_seen}, 32'h1);
      check("t4_busy_low", {31'h0, busy}, 32'h0);
      check("t4_data_kept", {24'h0, data}, 32'h0F);

      // Reset mid-frame after 4 data bits of 0xC3, then a clean 0x3C.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      check("t5_busy_before_rst", {31'h0, busy}, 32'h1);
      rstn = 1'b0;
      #1;
      check("t5_rst_busy", {31'h0, busy}, 32'h0);
      check("t5_rst_data", {24'h0, data}, 32'h00);
      check("t5_rst_rcv", {31'h0, rcv | frame_err}, 32'h0);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rstn = 1'b1;
      idle_bits(6);
      check("t5_idle_after_rst", {31'h0, busy}, 32'h0);
      q_main.push_back('{err: 1'b0, data: 8'h3C});
      send_frame(8'h3C, 1'b1);
      idle_bits(2);
      check("t5_data", {24'h0, data}, 32'h3C);

      // Full byte sweep, in order, on the fast instance.
      for (int i = 0; i < 256; i++) begin
         q_fast.push_back('{err: 1'b0, data: 8'(i)});
         send_frame_fast(8'(i));
      end

      // Bounded drain of both scoreboards.
      for (int n = 0; n < 2000; n++) begin
         if ((q_main.size() == 0) && (q_fast.size() == 0)) break;
         @(posedge clk);
      end
      #1;
      check("drain_main", q_main.size(), 32'd0);
      check("drain_fast", q_fast.size(), 32'd0);
      check("t6_last_data", {24'h0, data_f}, 32'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
